// File: rtl/rf_op_sequencer.sv
// rtl/rf_op_sequencer.sv - register-file command sequencer (accept, read, execute, write-back)
// One command per four cycles; operands are captured before write-back so dst may alias a source.
module rf_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADR_W-1:0]  cmd_dst,
  input  logic [ADR_W-1:0]  cmd_srca,
  input  logic [ADR_W-1:0]  cmd_srcb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              we,
  output logic [ADR_W-1:0]  W_Adr,
  output logic [ADR_W-1:0]  R_Adr,
  output logic [ADR_W-1:0]  S_Adr,
  output logic [DATA_W-1:0] W,
  input  logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] S,
  output logic              done,
  output logic [3:0]        flags
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam int MSB = DATA_W - 1;

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] res;
  logic              res_c;
  logic              res_v;

  assign cmd_ready = (state == ST_IDLE);

  // The extra top bit of the widened difference is the unsigned borrow.
  assign sum_ext  = {1'b0, opa} + {1'b0, opb};
  assign diff_ext = {1'b0, opa} - {1'b0, opb};

  always_comb begin
    res   = opa;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        res   = sum_ext[DATA_W-1:0];
        res_c = sum_ext[DATA_W];
        res_v = (opa[MSB] == opb[MSB]) && (sum_ext[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        res   = diff_ext[DATA_W-1:0];
        res_c = diff_ext[DATA_W];
        res_v = (opa[MSB] != opb[MSB]) && (diff_ext[MSB] != opa[MSB]);
      end
      OP_AND:  res = opa & opb;
      OP_OR:   res = opa | opb;
      OP_XOR:  res = opa ^ opb;
      OP_LDI:  res = imm_q;
      default: res = opa;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= OP_MOV;
      imm_q <= '0;
      opa   <= '0;
      opb   <= '0;
      we    <= 1'b0;
      W_Adr <= '0;
      R_Adr <= '0;
      S_Adr <= '0;
      W     <= '0;
      done  <= 1'b0;
      flags <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          we   <= 1'b0;
          done <= 1'b0;
          if (cmd_valid) begin
            op_q  <= cmd_op;
            imm_q <= cmd_imm;
            R_Adr <= cmd_srca;
            S_Adr <= cmd_srcb;
            W_Adr <= cmd_dst;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          opa   <= R;
          opb   <= S;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // NOP still completes with done, but leaves W, flags and the file alone.
          if (op_q != OP_NOP) begin
            W     <= res;
            flags <= {res_c, res[MSB], ~|res, res_v};
            we    <= 1'b1;
          end
          done  <= 1'b1;
          state <= ST_WRITE;
        end
        default: begin
          we    <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
